softmax_argmax: RTL and testbench
=================================

Name: softmax_argmax

Overview:
- Downstream consumer of the softmax stage: captures its stream of N+1 IEEE-754 single-precision probabilities, buffers them, and tracks the running maximum.
- Reports the winning index and value through a valid/ready result handshake.
- Buffered values stay readable through a random-access read port until the next frame starts.

Parameters:
- DATALENGTH, 32: element width. The comparator decodes fp32, so 32 is the only supported value.
- INPUTMAX, 2: log2 of buffer depth. Depth = 2**INPUTMAX = 4 entries.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  frame start; sampled only in IDLE.
- N  in  INPUTMAX+1  element count minus one; latched on Start.
- In_valid  in  1  Datain carries a valid element this cycle.
- In_ready  out  1  block accepts an element this cycle; high only in COLLECT.
- Datain  in  DATALENGTH  fp32 element.
- Out_valid  out  1  result available.
- Out_ready  in  1  downstream consumes the result.
- Max_index  out  INPUTMAX  index of the maximum element.
- Max_value  out  DATALENGTH  value of the maximum element.
- Nan_seen  out  1  at least one NaN was seen in the frame.
- Busy  out  1  state is not IDLE.
- Rd_addr  in  INPUTMAX  buffer read address.
- Rd_data  out  DATALENGTH  combinational read of Buffer[Rd_addr].

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all buffer entries = 0; Cnt = 0.
  - Out_valid = 0, Max_index = 0, Max_value = 0, Nan_seen = 0, Busy = 0, In_ready = 0.
- States are IDLE, COLLECT and REPORT.
- IDLE:
  - On Start=1: latch Nl = min(N, 2**INPUTMAX-1); Cnt = 0; clear Nan_seen; running best invalid; go to COLLECT.
  - Start in any other state is ignored.
- COLLECT:
  - In_ready = 1.
  - Each cycle with In_valid=1: Buffer[Cnt] <= Datain; compare/update; Cnt++.
  - The cycle that accepts element Cnt==Nl moves to REPORT. Out_valid rises on the next edge, i.e. one cycle after the last accept.
  - In_valid=0 cycles stall with no state change.
  - No timeout.
- REPORT:
  - Out_valid = 1. Max_index, Max_value and Nan_seen are stable while Out_valid is high.
  - On Out_valid & Out_ready: Out_valid drops on the next edge and the state returns to IDLE.
  - Start arriving in the same cycle as the handshake is ignored; it must be reissued in IDLE.
- Compare rule:
  - NaN (exp=0xFF, mantissa!=0): never a candidate; sets Nan_seen.
  - -0 is canonicalised to +0 before keying.
  - Key = sign ? ~x : x ^ 32'h80000000; keys are compared unsigned.
  - ±Inf are ordinary candidates.
  - The first non-NaN element always becomes best. Later elements replace best only if key is strictly greater, so ties keep the lowest index.
- All-NaN frame: Max_index = 0, Max_value = 32'h7FC00000, Nan_seen = 1.
- Max_value holds the original bit pattern of the winner; -0 is not rewritten.
- Buffer entries with index > Nl keep stale contents. Rd_data is valid for indexes 0..Nl after REPORT until the next Start.
- N > 2**INPUTMAX-1 is clamped: exactly 2**INPUTMAX elements are accepted.
- Reset asserted mid-frame aborts immediately to reset values. No partial result is emitted.

Test Plan:
- Basic frame: N=3, stream 0x3DCCCCCD (0.1), 0x3F000000 (0.5), 0x3E4CCCCD (0.2), 0x3E4CCCCD (0.2), In_valid continuous.
  - Out_valid 1 cycle after the 4th accept.
  - Max_index=1, Max_value=0x3F000000, Nan_seen=0.
  - Rd_addr=2 gives Rd_data=0x3E4CCCCD.
- Ties and signs: N=3, stream 0xBF800000 (-1), 0x3F000000, 0x3F000000, 0x80000000 (-0).
  - Max_index=1, lowest of the tied elements.
  - Separate frame N=1 with -0 then +0: Max_index=0, Max_value=0x80000000.
- NaN handling:
  - N=2, stream 0x7FC00000, 0x3E800000, 0x7F800001: Max_index=1, Nan_seen=1.
  - All-NaN frame N=1: Max_index=0, Max_value=0x7FC00000.
- Backpressure and stalls:
  - In_valid toggling 1-0-1-0 mid-frame: only valid cycles counted; same result as the continuous stream.
  - Out_ready held low for 10 cycles: outputs stable, Busy=1; Start pulses during REPORT ignored.
  - Out_ready=1: return to IDLE the next cycle.
- Clamp: N=6 with 5 elements offered.
  - In_ready drops after 4 accepts; the 5th element is not taken.
  - Result covers indexes 0..3.
- Reset mid-frame: Reset low after 2 accepts.
  - All outputs reach reset values with no clock edge.
  - After release, a fresh N=0 frame with 0x40000000 gives Max_index=0, Max_value=0x40000000.

Source files
------------

// File: rtl/softmax_argmax.sv
// Argmax over a softmax probability frame: buffers up to 2**INPUTMAX fp32
// values, tracks the running maximum and reports it via valid/ready.
module softmax_argmax #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [INPUTMAX:0]     N,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [DATALENGTH-1:0] Datain,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [INPUTMAX-1:0]   Max_index,
    output logic [DATALENGTH-1:0] Max_value,
    output logic                  Nan_seen,
    output logic                  Busy,
    input  logic [INPUTMAX-1:0]   Rd_addr,
    output logic [DATALENGTH-1:0] Rd_data
);

    localparam int DEPTH = 2 ** INPUTMAX;
    localparam logic [DATALENGTH-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [DATALENGTH-1:0] NEG0 = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATALENGTH-1:0] buffer [DEPTH];
    logic [INPUTMAX-1:0]   cnt;
    logic [INPUTMAX-1:0]   nl;
    logic [INPUTMAX-1:0]   n_clamp;
    logic [DATALENGTH-1:0] best_key;
    logic                  best_valid;

    logic                  start_go;
    logic                  accept;
    logic                  last;
    logic                  is_nan;
    logic [DATALENGTH-1:0] canon;
    logic [DATALENGTH-1:0] key;
    logic                  better;

    // Counts above the buffer depth saturate to the last index.
    assign n_clamp = N[INPUTMAX] ? {INPUTMAX{1'b1}}
                                 : N[INPUTMAX-1:0];

    assign start_go = (state == IDLE) && Start;
    assign accept   = (state == COLLECT) && In_valid;
    assign last     = accept && (cnt == nl);

    // Order-preserving key: -0 folds onto +0, negatives invert, positives flip sign.
    always_comb begin
        is_nan = (&Datain[30:23]) && (|Datain[22:0]);
        canon  = (Datain == NEG0) ? '0 : Datain;
        key    = canon[31] ? ~canon : (canon ^ NEG0);
        better = !is_nan && (!best_valid || (key > best_key));
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (last) begin
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                if (Out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        In_ready  = (state == COLLECT);
        Out_valid = (state == REPORT);
        Busy      = (state != IDLE);
    end

    // Element buffer; written in arrival order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else if (accept) begin
            buffer[cnt] <= Datain;
        end
    end

    // Frame bookkeeping and running-maximum tracker.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt        <= '0;
            nl         <= '0;
            best_key   <= '0;
            best_valid <= 1'b0;
            Max_index  <= '0;
            Max_value  <= '0;
            Nan_seen   <= 1'b0;
        end else if (start_go) begin
            cnt        <= '0;
            nl         <= n_clamp;
            best_key   <= '0;
            best_valid <= 1'b0;
            Max_index  <= '0;
            Max_value  <= QNAN;
            Nan_seen   <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (is_nan) begin
                Nan_seen <= 1'b1;
            end
            if (better) begin
                best_valid <= 1'b1;
                best_key   <= key;
                Max_index  <= cnt;
                Max_value  <= Datain;
            end
        end
    end

    assign Rd_data = buffer[Rd_addr];

endmodule

// File: tb/tb_softmax_argmax.sv
// Bench for softmax_argmax: directed frames from the test plan followed by
// random frames, checked against an ordering model built on fp32 magnitudes.
module tb_softmax_argmax;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  N = 3'd0;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [31:0] Datain = 32'd0;
    logic        Out_valid;
    logic        Out_ready = 1'b0;
    logic [1:0]  Max_index;
    logic [31:0] Max_value;
    logic        Nan_seen;
    logic        Busy;
    logic [1:0]  Rd_addr = 2'd0;
    logic [31:0] Rd_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] stim [$];
    logic [31:0] acc [$];
    logic [31:0] mbuf [4];

    softmax_argmax #(.DATALENGTH(32), .INPUTMAX(2)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .N(N),
        .In_valid(In_valid), .In_ready(In_ready), .Datain(Datain),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Max_index(Max_index), .Max_value(Max_value),
        .Nan_seen(Nan_seen), .Busy(Busy),
        .Rd_addr(Rd_addr), .Rd_data(Rd_data)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Numeric "a > b" for non-NaN fp32; both zeros compare equal.
    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic [30:0] ma;
        logic [30:0] mb;
        logic sa;
        logic sb;
        ma = a[30:0];
        mb = b[30:0];
        sa = a[31] && (ma != 31'd0);
        sb = b[31] && (mb != 31'd0);
        if (sa != sb) return sb;
        if (!sa) return ma > mb;
        return ma < mb;
    endfunction

    task automatic model(output logic [31:0] ei, output logic [31:0] ev,
                         output logic [31:0] en);
        int best;
        best = -1;
        en = 32'd0;
        foreach (acc[i]) begin
            if (is_nan(acc[i])) en = 32'd1;
            else if (best < 0 || fp_gt(acc[i], acc[best])) best = i;
        end
        ei = (best < 0) ? 32'd0 : 32'(best);
        ev = (best < 0) ? 32'h7FC00000 : acc[best];
    endtask

    function automatic logic [31:0] gen();
        int c;
        logic [31:0] v;
        c = $urandom_range(0, 9);
        v = $urandom;
        case (c)
            0: begin
                v[30:23] = 8'hFF;
                if (v[22:0] == 23'd0) v[0] = 1'b1;
            end
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:0] = 31'd0;
            default: if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
        endcase
        return v;
    endfunction

    task automatic run_frame(input int n, input int offer, input bit gaps,
                             input int hold, input bit poke);
        int nl;
        int taken;
        int guard;
        bit ok;
        logic [31:0] ei;
        logic [31:0] ev;
        logic [31:0] en;
        nl = (n > 3) ? 3 : n;
        taken = 0;
        guard = 0;
        acc.delete();
        chk("idle_before_start", 32'(Busy), 32'd0);
        Start = 1'b1;
        N = 3'(n);
        step();
        Start = 1'b0;
        chk("in_ready_collect", 32'(In_ready), 32'd1);
        while (taken < offer && guard < 200) begin
            guard++;
            if (gaps && (guard % 2 == 0)) begin
                In_valid = 1'b0;
                step();
            end else begin
                In_valid = 1'b1;
                Datain = stim[taken];
                ok = In_ready;
                step();
                if (!ok) break;
                mbuf[taken] = stim[taken];
                acc.push_back(stim[taken]);
                taken++;
                if (taken == nl + 1)
                    chk("out_valid_after_last", 32'(Out_valid), 32'd1);
            end
        end
        if (taken < offer)
            chk("clamp_no_ready", 32'(In_ready), 32'd0);
        In_valid = 1'b0;
        chk("accept_count", 32'(taken), 32'(nl + 1));
        model(ei, ev, en);
        chk("out_valid", 32'(Out_valid), 32'd1);
        chk("busy_report", 32'(Busy), 32'd1);
        chk("max_index", 32'(Max_index), ei);
        chk("max_value", Max_value, ev);
        chk("nan_seen", 32'(Nan_seen), en);
        for (int h = 0; h < hold; h++) begin
            Start = poke && (h % 3 == 1);
            N = 3'd0;
            step();
            chk("hold_valid", 32'(Out_valid), 32'd1);
            chk("hold_index", 32'(Max_index), ei);
            chk("hold_value", Max_value, ev);
        end
        Start = poke;
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        Start = 1'b0;
        chk("out_valid_drop", 32'(Out_valid), 32'd0);
        chk("busy_idle", 32'(Busy), 32'd0);
        if (poke) begin
            step();
            chk("start_in_report_ignored", 32'(Busy), 32'd0);
        end
        for (int a = 0; a <= nl; a++) begin
            Rd_addr = 2'(a);
            #1;
            chk("rd_data", Rd_data, mbuf[a]);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(Out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(In_ready), 32'd0);
        chk({tag, "_index"}, 32'(Max_index), 32'd0);
        chk({tag, "_value"}, Max_value, 32'd0);
        chk({tag, "_nan"}, 32'(Nan_seen), 32'd0);
    endtask

    initial begin
        int n;
        int nl;
        int offer;
        foreach (mbuf[i]) mbuf[i] = 32'd0;

        #2 Reset = 1'b0;
        #1 reset_checks("reset");
        Rd_addr = 2'd3;
        #1 chk("reset_buffer", Rd_data, 32'd0);
        #9 Reset = 1'b1;
        step();

        stim = '{32'h3DCCCCCD, 32'h3F000000, 32'h3E4CCCCD, 32'h3E4CCCCD};
        run_frame(3, 4, 1'b0, 0, 1'b0);
        chk("basic_index", 32'(Max_index), 32'd1);
        chk("basic_value", Max_value, 32'h3F000000);
        Rd_addr = 2'd2;
        #1 chk("basic_rd2", Rd_data, 32'h3E4CCCCD);

        run_frame(3, 4, 1'b1, 0, 1'b0);
        chk("gaps_index", 32'(Max_index), 32'd1);
        chk("gaps_value", Max_value, 32'h3F000000);

        run_frame(3, 4, 1'b0, 10, 1'b1);

        stim = '{32'hBF800000, 32'h3F000000, 32'h3F000000, 32'h80000000};
        run_frame(3, 4, 1'b0, 0, 1'b0);
        chk("tie_index", 32'(Max_index), 32'd1);

        stim = '{32'h80000000, 32'h00000000};
        run_frame(1, 2, 1'b0, 0, 1'b0);
        chk("negzero_index", 32'(Max_index), 32'd0);
        chk("negzero_value", Max_value, 32'h80000000);

        stim = '{32'h7FC00000, 32'h3E800000, 32'h7F800001};
        run_frame(2, 3, 1'b0, 0, 1'b0);
        chk("nan_index", 32'(Max_index), 32'd1);
        chk("nan_flag", 32'(Nan_seen), 32'd1);

        stim = '{32'h7FC00000, 32'hFFC00001};
        run_frame(1, 2, 1'b0, 0, 1'b0);
        chk("allnan_index", 32'(Max_index), 32'd0);
        chk("allnan_value", Max_value, 32'h7FC00000);
        chk("allnan_flag", 32'(Nan_seen), 32'd1);

        stim = '{32'h3E000000, 32'h3E800000, 32'h3D800000,
                 32'h3F000000, 32'h3F400000};
        run_frame(6, 5, 1'b0, 0, 1'b0);
        chk("clamp_index", 32'(Max_index), 32'd3);
        chk("clamp_value", Max_value, 32'h3F000000);

        Start = 1'b1;
        N = 3'd3;
        step();
        Start = 1'b0;
        In_valid = 1'b1;
        Datain = 32'h3F800000;
        step();
        Datain = 32'h40400000;
        step();
        In_valid = 1'b0;
        Reset = 1'b0;
        #1 reset_checks("midreset");
        Rd_addr = 2'd1;
        #1 chk("midreset_buffer", Rd_data, 32'd0);
        foreach (mbuf[i]) mbuf[i] = 32'd0;
        #1 Reset = 1'b1;
        step();
        stim = '{32'h40000000};
        run_frame(0, 1, 1'b0, 0, 1'b0);
        chk("fresh_index", 32'(Max_index), 32'd0);
        chk("fresh_value", Max_value, 32'h40000000);

        for (int r = 0; r < 16; r++) begin
            n = $urandom_range(0, 7);
            nl = (n > 3) ? 3 : n;
            offer = nl + 1;
            if (n > 3 && $urandom_range(0, 1) == 1) offer = nl + 2;
            stim.delete();
            for (int k = 0; k < offer; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0)
                    stim.push_back(stim[k - 1]);
                else
                    stim.push_back(gen());
            end
            run_frame(n, offer, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
